// File: rtl/merge_tree_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : merge_tree_pkg
//  Description : Shared constants, FSM encoding and beat/address typedefs for
//                the P=16 merger tree write-back path.
//  Revision    : 1.0 - initial release
// ============================================================================
package merge_tree_pkg;

    // Records per beat produced by the root merger.
    localparam int P              = 16;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_ADDR_WIDTH = 64;
    localparam int BEAT_WIDTH     = P * DEF_DATA_WIDTH;
    localparam int BEAT_BYTES     = BEAT_WIDTH / 8;

    // Write-back FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } wb_state_t;

    typedef logic [BEAT_WIDTH-1:0]     beat_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

    // Byte stride between consecutive beats for a given record width.
    function automatic int beat_bytes(input int data_width);
        return (P * data_width) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/merge_tree_writeback_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_beat_fifo
//  Description : Synchronous first-word-fall-through beat buffer. The head
//                entry is visible on o_pop_data whenever o_empty is low.
//  Ports       : i_clk, i_rst          clock, synchronous active-high reset
//                i_push, i_push_data   write side (ignored when full)
//                i_pop                 consume head entry (ignored when empty)
//                o_pop_data            head entry
//                o_full, o_empty       occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_beat_fifo #(
    parameter int WIDTH = 2048,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push     = i_push & ~o_full;
    assign w_pop      = i_pop & ~o_empty;
    assign o_full     = (r_count == c_depth);
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            if (w_push && !w_pop)      r_count <= r_count + c_cw'(1);
            else if (w_pop && !w_push) r_count <= r_count - c_cw'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/merge_tree_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : merge_tree_writeback
//  Description : Root-side consumer of the P=16 merger tree. Buffers sorted
//                beats and writes them to memory as BURST_LEN-beat bursts at
//                incrementing addresses, one command per sorted run.
//  Ports       : i_clk, i_rst                 clock, sync active-high reset
//                i_start, i_base_addr,
//                i_num_beats                  run command (sampled in IDLE)
//                i_data, i_data_valid,
//                o_data_ready                 beat stream from root merger
//                o_wr_valid, o_wr_addr,
//                o_wr_data, o_wr_last,
//                i_wr_ready                   memory write port
//                o_busy, o_done               run status
//                o_order_err                  only with WB_ORDER_CHECK_EN
//  Config      : `define WB_ORDER_CHECK_EN adds a sticky sort-order checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module merge_tree_writeback
    import merge_tree_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_LEN  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [CNT_WIDTH-1:0]    i_num_beats,
    input  logic [P*DATA_WIDTH-1:0] i_data,
    input  logic                    i_data_valid,
    output logic                    o_data_ready,
    output logic                    o_wr_valid,
    output logic [ADDR_WIDTH-1:0]   o_wr_addr,
    output logic [P*DATA_WIDTH-1:0] o_wr_data,
    output logic                    o_wr_last,
    input  logic                    i_wr_ready,
    output logic                    o_busy,
    output logic                    o_done
`ifdef WB_ORDER_CHECK_EN
    ,
    output logic                    o_order_err
`endif
);

    localparam int c_bw  = P * DATA_WIDTH;
    localparam int c_bcw = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_stride    = ADDR_WIDTH'(beat_bytes(DATA_WIDTH));
    localparam logic [c_bcw-1:0]      c_burst_max = c_bcw'(BURST_LEN - 1);

    wb_state_t             r_state;
    logic [CNT_WIDTH-1:0]  r_num;
    logic [CNT_WIDTH-1:0]  r_accepted;
    logic [CNT_WIDTH-1:0]  r_written;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_bcw-1:0]      r_burst_cnt;

    logic                  w_active;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_data_ready;
    logic                  w_accept;
    logic                  w_wr_valid;
    logic                  w_wr_fire;
    logic [c_bw-1:0]       w_head;

    // Ready depends only on registered state, never on i_wr_ready, so the
    // tree is isolated from memory backpressure timing.
    assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_data_ready = (r_state == S_RUN) && !w_full && (r_accepted != r_num);
    assign w_accept     = i_data_valid & w_data_ready;
    assign w_wr_valid   = w_active & ~w_empty;
    assign w_wr_fire    = w_wr_valid & i_wr_ready;

    wb_beat_fifo #(
        .WIDTH (c_bw),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_accept),
        .i_push_data (i_data),
        .i_pop       (w_wr_fire),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_accepted  <= '0;
            r_written   <= '0;
            r_addr      <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num       <= i_num_beats;
                        r_addr      <= i_base_addr;
                        r_accepted  <= '0;
                        r_written   <= '0;
                        r_burst_cnt <= '0;
                        r_state     <= (i_num_beats == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept && ((r_accepted + CNT_WIDTH'(1)) == r_num)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_written == r_num) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_accept) begin
                r_accepted <= r_accepted + CNT_WIDTH'(1);
            end

            if (w_wr_fire) begin
                r_addr      <= r_addr + c_stride;
                r_written   <= r_written + CNT_WIDTH'(1);
                r_burst_cnt <= (r_burst_cnt == c_burst_max) ? '0 : r_burst_cnt + c_bcw'(1);
            end
        end
    end

    assign o_data_ready = w_data_ready;
    assign o_wr_valid   = w_wr_valid;
    assign o_wr_addr    = r_addr;
    // Gated so the port reads zero whenever no beat is offered.
    assign o_wr_data    = w_wr_valid ? w_head : '0;
    assign o_wr_last    = w_wr_valid &
                          ((r_burst_cnt == c_burst_max) ||
                           (r_written == (r_num - CNT_WIDTH'(1))));
    assign o_busy       = w_active;
    assign o_done       = (r_state == S_DONE);

`ifdef WB_ORDER_CHECK_EN
    logic [DATA_WIDTH-1:0] r_prev_rec;
    logic                  r_have_prev;
    logic                  r_order_err;
    logic [P-1:0]          w_rec_bad;

    // Record 0 is compared against the last record of the previous beat of
    // the same run; every other record against its lower neighbour.
    generate
        for (genvar k = 0; k < P; k++) begin : g_order
            if (k == 0) begin : g_first
                assign w_rec_bad[k] = r_have_prev &&
                                      (i_data[0 +: DATA_WIDTH] < r_prev_rec);
            end else begin : g_rest
                assign w_rec_bad[k] = (i_data[k*DATA_WIDTH +: DATA_WIDTH] <
                                       i_data[(k-1)*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_rec  <= '0;
            r_have_prev <= 1'b0;
            r_order_err <= 1'b0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_have_prev <= 1'b0;
            r_order_err <= 1'b0;
        end else if (w_accept) begin
            r_prev_rec  <= i_data[(P-1)*DATA_WIDTH +: DATA_WIDTH];
            r_have_prev <= 1'b1;
            if (|w_rec_bad) begin
                r_order_err <= 1'b1;
            end
        end
    end

    assign o_order_err = r_order_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_merge_tree_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_merge_tree_writeback
//  Description : Randomized self-checking bench for merge_tree_writeback.
//                A queue of accepted beats is the reference; each write is
//                checked for data, address and burst framing, and ready/busy
//                are compared against occupancy derived from handshake counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_merge_tree_writeback;
    import merge_tree_pkg::*;

    localparam int DW = 128;
    localparam int AW = 64;
    localparam int CW = 32;
    localparam int FD = 8;
    localparam int BL = 16;
    localparam int BW = BEAT_WIDTH;

    logic          clk;
    logic          i_rst;
    logic          i_start;
    addr_t         i_base_addr;
    logic [CW-1:0] i_num_beats;
    beat_t         i_data;
    logic          i_data_valid;
    logic          o_data_ready;
    logic          o_wr_valid;
    addr_t         o_wr_addr;
    beat_t         o_wr_data;
    logic          o_wr_last;
    logic          i_wr_ready;
    logic          o_busy;
    logic          o_done;
`ifdef WB_ORDER_CHECK_EN
    logic          o_order_err;
`endif

    merge_tree_writeback #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW),
        .FIFO_DEPTH (FD),
        .BURST_LEN  (BL)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_num_beats  (i_num_beats),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .o_wr_valid   (o_wr_valid),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_wr_last    (o_wr_last),
        .i_wr_ready   (i_wr_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
`ifdef WB_ORDER_CHECK_EN
        ,
        .o_order_err  (o_order_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compares a full beat, reporting the first differing record.
    task automatic check_beat(input string tag, input beat_t got, input beat_t exp);
        int bad = 0;
        for (int k = P - 1; k >= 0; k--) begin
            if (got[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
        end
        check($sformatf("%s rec%0d", tag, bad), got[bad*DW +: DW], exp[bad*DW +: DW]);
    endtask

    // Source beats: records ascend within and across beats of a run.
    beat_t       src_beat;
    logic [31:0] run_hi;
    logic [95:0] last_lo;
    beat_t       exp_q[$];

    task automatic gen_beat();
        for (int k = 0; k < P; k++) begin
            last_lo = last_lo + 96'($urandom_range(1, 1000));
            src_beat[k*DW +: DW] = {run_hi, last_lo};
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: valid and wr_ready always high
    // mode 1: random valid and wr_ready
    // mode 2: valid always high, wr_ready low for 20 cycles from cycle 5
    task automatic run(input addr_t base, input int num, input int mode, input bit inject);
        int     acc = 0;
        int     wr = 0;
        int     done_cnt = 0;
        int     done_iter = -1;
        int     lastwr_iter = -1;
        int     ready_bad = 0;
        int     busy_bad = 0;
        int     it = 0;
        int     inj_iter = -1;
        bit     prev_stall = 0;
        bit     ready_exp;
        bit     busy_exp;
        addr_t  prev_addr = '0;
        beat_t  prev_data = '0;
        addr_t  exp_addr;
        bit     exp_last;

        run_hi  = $urandom;
        last_lo = '0;
        exp_q.delete();
        gen_beat();

        i_start      = 1'b1;
        i_base_addr  = base;
        i_num_beats  = CW'(num);
        i_data_valid = 1'b0;
        i_wr_ready   = 1'b0;
        step();
        i_start      = 1'b0;
        // Command must have been latched; scramble the inputs.
        i_base_addr  = {$urandom, $urandom};
        i_num_beats  = $urandom;

        while (it < 3000) begin
            if (o_done) begin
                done_cnt++;
                if (done_iter < 0) done_iter = it;
            end
            busy_exp  = (num != 0) && (done_cnt == 0);
            ready_exp = (acc < num) && ((acc - wr) < FD);
            if (o_busy !== busy_exp)        busy_bad++;
            if (o_data_ready !== ready_exp) ready_bad++;

            if (prev_stall) begin
                check("stall_addr", o_wr_addr, prev_addr);
                check_beat("stall_data", o_wr_data, prev_data);
            end

            case (mode)
                0:       i_wr_ready = 1'b1;
                2:       i_wr_ready = !(it >= 5 && it < 25);
                default: i_wr_ready = ($urandom_range(0, 3) != 0);
            endcase

            prev_stall = 0;
            if (o_wr_valid) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    exp_addr = base + addr_t'(wr) * addr_t'(BEAT_BYTES);
                    exp_last = ((wr % BL) == BL - 1) || (wr == num - 1);
                    check_beat($sformatf("wr_data[%0d]", wr), o_wr_data, exp_q[0]);
                    check($sformatf("wr_addr[%0d]", wr), o_wr_addr, exp_addr);
                    check($sformatf("wr_last[%0d]", wr), o_wr_last, exp_last);
                    if (i_wr_ready) begin
                        void'(exp_q.pop_front());
                        wr++;
                        lastwr_iter = it;
                    end else begin
                        prev_stall = 1;
                        prev_addr  = o_wr_addr;
                        prev_data  = o_wr_data;
                    end
                end
            end

            if (acc < num) begin
                i_data_valid = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
                i_data       = src_beat;
                if (i_data_valid && o_data_ready) begin
                    exp_q.push_back(src_beat);
`ifdef WB_ORDER_CHECK_EN
                    if (inject && acc == 1) inj_iter = it;
`endif
                    acc++;
                    gen_beat();
                    // Second beat starts below the first beat's last record.
                    if (inject && acc == 1) src_beat[DW-1:0] = '0;
                end
            end else begin
                i_data_valid = 1'b0;
            end

`ifdef WB_ORDER_CHECK_EN
            if (inject && inj_iter == it)              check("order_err_before", o_order_err, 0);
            if (inject && inj_iter >= 0 && it == inj_iter + 1) check("order_err_rise", o_order_err, 1);
`endif
            step();
            it++;
            if (done_cnt > 0 && it > done_iter + 3) break;
        end

        i_data_valid = 1'b0;
        i_wr_ready   = 1'b0;
        check($sformatf("run%0d_done_seen", num), (done_cnt > 0), 1);
        check($sformatf("run%0d_done_count", num), done_cnt, 1);
        check($sformatf("run%0d_accepts", num), acc, num);
        check($sformatf("run%0d_writes", num), wr, num);
        check($sformatf("run%0d_queue_left", num), exp_q.size(), 0);
        check($sformatf("run%0d_ready_bad", num), ready_bad, 0);
        check($sformatf("run%0d_busy_bad", num), busy_bad, 0);
        if (num == 0) check("run0_done_delay", done_iter, 0);
        else          check($sformatf("run%0d_done_delay", num), done_iter - lastwr_iter, 2);
`ifdef WB_ORDER_CHECK_EN
        check($sformatf("run%0d_order_err", num), o_order_err, inject);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_valid"}, o_wr_valid, 0);
        check({tag, "_data_ready"}, o_data_ready, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_wr_addr"}, o_wr_addr, 0);
        check({tag, "_wr_last"}, o_wr_last, 0);
        check_beat({tag, "_wr_data"}, o_wr_data, '0);
`ifdef WB_ORDER_CHECK_EN
        check({tag, "_order_err"}, o_order_err, 0);
`endif
    endtask

    // Accepts 3 of 10 beats with memory stalled, then resets mid-run.
    task automatic reset_mid();
        int acc = 0;
        int dones = 0;
        run_hi  = $urandom;
        last_lo = '0;
        gen_beat();
        i_start     = 1'b1;
        i_base_addr = 64'h8000;
        i_num_beats = 10;
        i_wr_ready  = 1'b0;
        step();
        i_start = 1'b0;
        for (int c = 0; c < 50 && acc < 3; c++) begin
            i_data_valid = 1'b1;
            i_data       = src_beat;
            if (o_data_ready) begin
                acc++;
                gen_beat();
            end
            step();
        end
        i_data_valid = 1'b0;
        check("mid_accepts", acc, 3);
        i_rst = 1'b1;
        step();
        check_reset_outputs("mid_rst");
        i_rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (o_done || o_wr_valid || o_busy) dones++;
            step();
        end
        check("mid_rst_quiet", dones, 0);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_base_addr  = '0;
        i_num_beats  = '0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_wr_ready   = 1'b0;
        src_beat     = '0;
        run_hi       = '0;
        last_lo      = '0;
        step();
        step();
        check_reset_outputs("reset");
        i_rst = 1'b0;
        step();

        run(64'h1000, 4, 0, 0);
        run(64'h2000, 40, 0, 0);
        run(64'h3000, 30, 2, 0);
        run(64'h4000, 0, 1, 0);
        reset_mid();
        run(64'h9000, 2, 1, 0);
        run(64'hFFFF_FFFF_FFFF_FE00, 4, 1, 0);
        run(64'h5000, 17, 1, 0);
`ifdef WB_ORDER_CHECK_EN
        run(64'h6000, 6, 1, 1);
        run(64'h7000, 3, 1, 0);
`endif
        for (int r = 0; r < 4; r++) begin
            run({$urandom, $urandom} & ~64'hFF, $urandom_range(1, 50), 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
